// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               synchronous memory. One access in flight at a time:
//               IDLE -> ACCESS (one strobe cycle) -> RDWAIT (reads only).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_grant;   // 1 after reset so requester 0 wins the first tie
  logic            r_owner;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;
  logic            w_sel1;         // requester 1 selected this IDLE cycle
  logic            w_xfer;         // a transfer happens on the coming edge

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state, selection and ready handshake (ready only in IDLE)
  always_comb begin
    w_next     = r_state;
    w_sel1     = 1'b0;
    w_xfer     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // requester 1 wins if alone, or on a tie when 0 was granted last
        w_sel1     = req1_valid && (!req0_valid || !r_last_grant);
        req1_ready = w_sel1;
        req0_ready = req0_valid && !w_sel1;
        w_xfer     = req0_valid || req1_valid;
        if (w_xfer) w_next = ACCESS;
      end
      ACCESS:  w_next = r_we ? IDLE : RDWAIT;
      RDWAIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the granted request and remember the owner for round-robin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_xfer) begin
      r_last_grant <= w_sel1;
      r_owner      <= w_sel1;
      r_we         <= w_sel1 ? req1_we    : req0_we;
      r_addr       <= w_sel1 ? req1_addr  : req0_addr;
      r_wdata      <= w_sel1 ? req1_wdata : req0_wdata;
    end
  end

  // Hold each requester's last returned read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == RDWAIT) begin
      if (r_owner) r_rdata1 <= mem_rdata;
      else         r_rdata0 <= mem_rdata;
    end
  end

  // Memory strobes are decoded from state so they can never overlap
  assign mem_write   = (r_state == ACCESS) &&  r_we;
  assign mem_read    = (r_state == ACCESS) && !r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = (r_state != IDLE);

  // Read data returns straight from memory in RDWAIT, then is held
  assign req0_rvalid = (r_state == RDWAIT) && !r_owner;
  assign req1_rvalid = (r_state == RDWAIT) &&  r_owner;
  assign req0_rdata  = req0_rvalid ? mem_rdata : r_rdata0;
  assign req1_rdata  = req1_rvalid ? mem_rdata : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model predicts grants, strobes and read returns per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req0_ready, req0_rvalid;
  logic [DW-1:0] req0_rdata;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req1_ready, req1_rvalid;
  logic [DW-1:0] req1_rdata;
  logic          mem_write, mem_read, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment memory: synchronous, read data registered on the read edge
  logic [DW-1:0] env_mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) env_mem[i] = '0;
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= env_mem[mem_addr];
  end

  // Reference model state (transaction level)
  logic [DW-1:0] model_mem [2**AW];
  int            cyc = 0;
  int            free_at = 0;    // first cycle the arbiter may grant again
  int            last = 1;       // last granted requester
  int            s_cyc = -1;     // cycle of the expected memory strobe
  bit            s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  int            r_cyc = -1;     // cycle of the expected rvalid pulse
  int            r_own;
  logic [DW-1:0] r_data;
  logic [DW-1:0] last_rd;
  int            mode = 0;       // 0 drop after grant, 1 re-raise, 2 random
  int            grants[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic rand_req(input int n);
    set_req(n, 1'($urandom_range(1)), AW'($urandom_range(2**AW-1)), DW'($urandom));
  endtask

  // One clock cycle: predict and compare at the negedge, then advance
  task automatic step();
    int g;
    bit exp_rv0, exp_rv1;
    @(negedge clk);
    g = -1;
    if (cyc >= free_at) begin
      if (req0_valid && req1_valid) g = 1 - last;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    check("busy",     busy,       cyc < free_at);
    check("ready0",   req0_ready, g == 0);
    check("ready1",   req1_ready, g == 1);
    check("rdy_both", req0_ready & req1_ready, 0);
    if (cyc == s_cyc) begin
      check("mem_write", mem_write, s_we);
      check("mem_read",  mem_read,  !s_we);
      check("mem_addr",  mem_addr,  s_addr);
      if (s_we) check("mem_wdata", mem_wdata, s_data);
    end else begin
      check("mem_write", mem_write, 0);
      check("mem_read",  mem_read,  0);
    end
    exp_rv0 = (cyc == r_cyc) && (r_own == 0);
    exp_rv1 = (cyc == r_cyc) && (r_own == 1);
    check("rvalid0", req0_rvalid, exp_rv0);
    check("rvalid1", req1_rvalid, exp_rv1);
    if (exp_rv0) begin check("rdata0", req0_rdata, r_data); last_rd = req0_rdata; end
    if (exp_rv1) begin check("rdata1", req1_rdata, r_data); last_rd = req1_rdata; end
    if (g >= 0) begin
      s_cyc  = cyc + 1;
      s_we   = (g == 0) ? req0_we    : req1_we;
      s_addr = (g == 0) ? req0_addr  : req1_addr;
      s_data = (g == 0) ? req0_wdata : req1_wdata;
      if (s_we) begin
        model_mem[s_addr] = s_data;
        free_at = cyc + 2;
      end else begin
        r_cyc   = cyc + 2;
        r_own   = g;
        r_data  = model_mem[s_addr];
        free_at = cyc + 3;
      end
      last = g;
      grants.push_back(g);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g == 0) begin
      if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) rand_req(0);
      else req0_valid = 1'b0;
    end
    if (g == 1) begin
      if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) rand_req(1);
      else req1_valid = 1'b0;
    end
    if (mode == 2) begin
      if (!req0_valid && $urandom_range(2) == 0) rand_req(0);
      if (!req1_valid && $urandom_range(2) == 0) rand_req(1);
    end
  endtask

  // Run until both requesters are served and the arbiter is idle
  task automatic drain();
    int n;
    n = 0;
    while ((req0_valid || req1_valid || cyc < free_at) && n < 20) begin
      step();
      n++;
    end
    check("drain_timeout", n < 20, 1);
  endtask

  // Assert reset away from the clock edge and check the held values
  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2;
    check("rst_busy",   busy, 0);
    check("rst_strobe", {mem_write, mem_read}, 0);
    check("rst_ready",  {req0_ready, req1_ready}, 0);
    check("rst_rvalid", {req0_rvalid, req1_rvalid}, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_wdata",  mem_wdata, 0);
    check("rst_rdata",  {req0_rdata, req1_rdata}, 0);
    @(posedge clk);
    #1;
    cyc++;
    check("rst_hold_busy", busy, 0);
    rst_n   = 1'b1;
    last    = 1;
    s_cyc   = -1;
    r_cyc   = -1;
    free_at = cyc;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
    apply_reset();

    // Lone write, then read back by the other requester
    set_req(0, 1'b1, 5'd5, 8'hA5);
    step(); step(); step();
    set_req(1, 1'b0, 5'd5, 8'h00);
    drain();
    check("rd_a5", last_rd, 8'hA5);

    // First tie after reset goes to requester 0
    apply_reset();
    grants.delete();
    set_req(0, 1'b1, 5'd1, 8'h11);
    set_req(1, 1'b1, 5'd2, 8'h22);
    drain();
    check("tie_n", grants.size(), 2);
    if (grants.size() == 2) begin
      check("tie_g0", grants[0], 0);
      check("tie_g1", grants[1], 1);
    end

    // Both held valid: strict alternation
    grants.delete();
    mode = 1;
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 40 && grants.size() < 6; i++) step();
    mode = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    check("rr_n", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("rr_order", grants[i], i % 2);

    // Reset during the read-return cycle abandons the read
    set_req(0, 1'b0, 5'd2, 8'h00);
    step(); step();
    check("at_rdwait", cyc == r_cyc, 1);
    apply_reset();
    step(); step();
    set_req(1, 1'b1, 5'd31, 8'h3C);
    drain();
    set_req(0, 1'b0, 5'd31, 8'h00);
    drain();
    check("rd_3c", last_rd, 8'h3C);

    // Randomized traffic
    mode = 2;
    for (int i = 0; i < 400; i++) step();
    mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
